// File: rtl/mem_responder_if.sv
// Request/response bundle between the sequence controller (master) and
// the memory responder (slave).
interface mem_responder_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
);
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data_in;
    logic              mem_rd;
    logic              mem_wr;
    logic [DWIDTH-1:0] data_out;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output addr, data_in, mem_rd, mem_wr,
        input  data_out, ready, busy, err
    );

    modport slave (
        input  addr, data_in, mem_rd, mem_wr,
        output data_out, ready, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: detects rising edges of the controller's mem_rd /
// mem_wr strobes, inserts WAIT_CYCLES wait states, then performs the access
// on an internal DEPTH x DWIDTH array and pulses ready for one cycle.
module mem_responder #(
    parameter int AWIDTH      = 5,
    parameter int DWIDTH      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,     // asynchronous, active-low
    mem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** AWIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_rd_q;
    logic              r_wr_q;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_data;
    logic              r_op_wr;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;
    logic              r_rd_seen;   // a read has completed since reset

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_mem_q;

    logic              w_rd_rise;
    logic              w_wr_rise;
    logic              w_single;
    logic              w_both;
    logic              w_enter_resp;
    logic              w_enter_wr;
    logic [AWIDTH-1:0] w_acc_addr;
    logic [DWIDTH-1:0] w_acc_data;
    logic              w_mem_we;
    logic              w_mem_re;

    assign w_rd_rise = bus.mem_rd & ~r_rd_q;
    assign w_wr_rise = bus.mem_wr & ~r_wr_q;
    assign w_single  = w_rd_rise ^ w_wr_rise;
    assign w_both    = w_rd_rise & w_wr_rise;

    // With zero wait states the access happens on the accept edge itself, so
    // the array sees the live request; otherwise it sees the latched one.
    always_comb begin
        w_enter_resp = 1'b0;
        w_enter_wr   = r_op_wr;
        w_acc_addr   = r_addr;
        w_acc_data   = r_data;
        if (r_state == S_IDLE) begin
            w_enter_resp = (WAIT_CYCLES == 0) && w_single;
            w_enter_wr   = w_wr_rise;
            w_acc_addr   = bus.addr;
            w_acc_data   = bus.data_in;
        end else if (r_state == S_WAIT) begin
            w_enter_resp = (r_cnt == 4'd1);
        end
    end

    // Reset held low must never let an access reach the array.
    assign w_mem_we = rst & w_enter_resp & w_enter_wr;
    assign w_mem_re = rst & w_enter_resp & ~w_enter_wr;

    // Array access on the RESP-entry edge: write, or registered read.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_acc_addr] <= w_acc_data;
        end
        if (w_mem_re) begin
            r_mem_q <= r_mem[w_acc_addr];
        end
    end

    // Control FSM: strobe history, request accept, wait count, response pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_rd_q    <= 1'b0;
            r_wr_q    <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_op_wr   <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_seen <= 1'b0;
        end else begin
            r_rd_q  <= bus.mem_rd;
            r_wr_q  <= bus.mem_wr;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        r_addr  <= bus.addr;
                        r_data  <= bus.data_in;
                        r_op_wr <= w_wr_rise;
                        r_busy  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                            if (w_rd_rise) begin
                                r_rd_seen <= 1'b1;
                            end
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES);
                        end
                    end else if (w_both) begin
                        r_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        if (!r_op_wr) begin
                            r_rd_seen <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read data is zero until the first read after reset, then holds.
    assign bus.data_out = r_rd_seen ? r_mem_q : '0;
    assign bus.ready    = r_ready;
    assign bus.busy     = r_busy;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states, one with none.
// Expected responses are queued when a request is driven and popped when the
// responder completes it.
module tb_mem_responder;
    localparam int AW = 5;
    localparam int DW = 8;

    typedef struct {
        int          d;
        bit          wr;
        logic [DW-1:0] data;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if #(.AWIDTH(AW), .DWIDTH(DW)) bus_a ();
    mem_responder_if #(.AWIDTH(AW), .DWIDTH(DW)) bus_b ();

    mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    logic [AW-1:0] t_addr [2];
    logic [DW-1:0] t_din  [2];
    logic          t_rd   [2];
    logic          t_wr   [2];
    logic [DW-1:0] o_dout [2];
    logic          o_ready[2];
    logic          o_busy [2];
    logic          o_err  [2];

    assign bus_a.addr    = t_addr[0];
    assign bus_a.data_in = t_din[0];
    assign bus_a.mem_rd  = t_rd[0];
    assign bus_a.mem_wr  = t_wr[0];
    assign bus_b.addr    = t_addr[1];
    assign bus_b.data_in = t_din[1];
    assign bus_b.mem_rd  = t_rd[1];
    assign bus_b.mem_wr  = t_wr[1];
    assign o_dout[0]  = bus_a.data_out;
    assign o_ready[0] = bus_a.ready;
    assign o_busy[0]  = bus_a.busy;
    assign o_err[0]   = bus_a.err;
    assign o_dout[1]  = bus_b.data_out;
    assign o_ready[1] = bus_b.ready;
    assign o_busy[1]  = bus_b.busy;
    assign o_err[1]   = bus_b.err;

    int total = 0;
    int bad   = 0;
    int waits [2] = '{2, 0};
    logic [DW-1:0] model_mem [2][32];
    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one single-cycle strobe and follows it until busy drops.
    task automatic access(input int d, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] din, output int lat,
                          output int bc, output logic [DW-1:0] dout);
        exp_t e;
        e.d    = d;
        e.wr   = wr;
        e.lat  = waits[d] + 1;
        e.data = wr ? din : model_mem[d][a];
        if (wr) model_mem[d][a] = din;
        sb.push_back(e);
        t_addr[d] = a;
        t_din[d]  = din;
        t_rd[d]   = !wr;
        t_wr[d]   = wr;
        lat  = -1;
        bc   = 0;
        dout = 'x;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 0) begin
                t_rd[d] = 1'b0;
                t_wr[d] = 1'b0;
            end
            if (o_busy[d]) bc++;
            if (o_ready[d] && lat < 0) begin
                lat  = k + 1;
                dout = o_dout[d];
            end
            if (!o_busy[d]) break;
        end
        $display("txn dut=%0d %s addr=%0d data=%02h latency=%0d busy_cycles=%0d",
                 d, wr ? "WR" : "RD", a, wr ? din : dout, lat, bc);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            t_addr[d] = '0; t_din[d] = '0; t_rd[d] = 1'b0; t_wr[d] = 1'b0;
        end
        tick(); tick(); tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({o_dout[d], o_ready[d], o_busy[d], o_err[d]} !== 11'd0) begin
                bad++;
                $display("FAIL reset_outputs dut=%0d: got dout=%02h rdy=%b busy=%b err=%b, required all 0",
                         d, o_dout[d], o_ready[d], o_busy[d], o_err[d]);
            end
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        int lat, bc; logic [DW-1:0] dout; exp_t e;
        access(0, 1'b1, 5'd3, 8'hA5, lat, bc, dout);
        e = sb.pop_front(); total++;
        if (lat !== e.lat || bc !== e.lat) begin
            bad++; $display("FAIL wr_a5: lat=%0d busy=%0d, required %0d/%0d", lat, bc, e.lat, e.lat);
        end
        access(0, 1'b0, 5'd3, 8'h00, lat, bc, dout);
        e = sb.pop_front(); total++;
        if (lat !== e.lat || bc !== e.lat || dout !== e.data) begin
            bad++; $display("FAIL rd_a5: lat=%0d busy=%0d data=%02h, required %0d/%0d/%02h",
                            lat, bc, dout, e.lat, e.lat, e.data);
        end
        access(0, 1'b1, 5'd4, 8'h5A, lat, bc, dout);
        e = sb.pop_front(); total++;
        if (lat !== e.lat || o_dout[0] !== 8'hA5) begin
            bad++; $display("FAIL data_hold: lat=%0d dout=%02h, required %0d/a5", lat, o_dout[0], e.lat);
        end
    endtask

    task automatic test_zero_wait();
        int lat, bc; logic [DW-1:0] dout; exp_t e;
        access(1, 1'b1, 5'd0, 8'h3C, lat, bc, dout);
        e = sb.pop_front(); total++;
        if (lat !== e.lat || bc !== e.lat) begin
            bad++; $display("FAIL w0_wr: lat=%0d busy=%0d, required %0d/%0d", lat, bc, e.lat, e.lat);
        end
        access(1, 1'b0, 5'd0, 8'h00, lat, bc, dout);
        e = sb.pop_front(); total++;
        if (lat !== e.lat || bc !== e.lat || dout !== e.data) begin
            bad++; $display("FAIL w0_rd: lat=%0d busy=%0d data=%02h, required %0d/%0d/%02h",
                            lat, bc, dout, e.lat, e.lat, e.data);
        end
    endtask

    task automatic test_held_strobe();
        int lat, bc, rdy; logic [DW-1:0] dout; exp_t e;
        access(0, 1'b1, 5'd12, 8'h6B, lat, bc, dout);
        void'(sb.pop_front());
        e.d = 0; e.wr = 1'b0; e.data = model_mem[0][12]; e.lat = waits[0] + 1;
        sb.push_back(e);
        t_addr[0] = 5'd12; t_rd[0] = 1'b1; rdy = 0; dout = 'x;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 2) t_rd[0] = 1'b0;
            if (o_ready[0]) begin rdy++; dout = o_dout[0]; end
        end
        $display("txn dut=0 RD held addr=12 data=%02h ready_pulses=%0d", dout, rdy);
        e = sb.pop_front(); total++;
        if (rdy !== 1 || dout !== e.data) begin
            bad++; $display("FAIL held_rd: pulses=%0d data=%02h, required 1/%02h", rdy, dout, e.data);
        end
        access(0, 1'b0, 5'd12, 8'h00, lat, bc, dout);
        e = sb.pop_front(); total++;
        if (lat !== e.lat || dout !== e.data) begin
            bad++; $display("FAIL reraise_rd: lat=%0d data=%02h, required %0d/%02h", lat, dout, e.lat, e.data);
        end
    endtask

    task automatic test_simultaneous();
        int lat, bc, rdy, errs; logic [DW-1:0] dout; exp_t e;
        access(0, 1'b1, 5'd7, 8'h11, lat, bc, dout);
        void'(sb.pop_front());
        t_addr[0] = 5'd7; t_din[0] = 8'hFF; t_rd[0] = 1'b1; t_wr[0] = 1'b1;
        tick();
        $display("txn dut=0 RD+WR addr=7 err=%b busy=%b", o_err[0], o_busy[0]);
        total++;
        if (o_err[0] !== 1'b1 || o_busy[0] !== 1'b0) begin
            bad++; $display("FAIL both_err: err=%b busy=%b, required 1/0", o_err[0], o_busy[0]);
        end
        t_rd[0] = 1'b0; t_wr[0] = 1'b0;
        rdy = 0; errs = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (o_ready[0]) rdy++;
            if (o_err[0]) errs++;
        end
        total++;
        if (rdy !== 0 || errs !== 0) begin
            bad++; $display("FAIL both_quiet: ready=%0d err=%0d, required 0/0", rdy, errs);
        end
        access(0, 1'b0, 5'd7, 8'h00, lat, bc, dout);
        e = sb.pop_front(); total++;
        if (lat !== e.lat || dout !== e.data) begin
            bad++; $display("FAIL both_nowrite: lat=%0d data=%02h, required %0d/%02h", lat, dout, e.lat, e.data);
        end
    endtask

    task automatic test_busy_rise();
        int lat, bc, rdy, errs; logic [DW-1:0] dout; exp_t e;
        model_mem[0][5] = 8'h44;
        t_addr[0] = 5'd5; t_din[0] = 8'h44; t_wr[0] = 1'b1; rdy = 0; errs = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) t_wr[0] = 1'b0;
            if (k == 1) begin t_wr[0] = 1'b1; t_din[0] = 8'h99; end
            if (k == 2) t_wr[0] = 1'b0;
            if (o_ready[0]) rdy++;
            if (o_err[0]) errs++;
        end
        $display("txn dut=0 WR repulsed addr=5 data=44 ready_pulses=%0d", rdy);
        total++;
        if (rdy !== 1 || errs !== 0 || o_busy[0] !== 1'b0) begin
            bad++; $display("FAIL busy_rise: pulses=%0d err=%0d busy=%b, required 1/0/0", rdy, errs, o_busy[0]);
        end
        access(0, 1'b0, 5'd5, 8'h00, lat, bc, dout);
        e = sb.pop_front(); total++;
        if (lat !== e.lat || dout !== e.data) begin
            bad++; $display("FAIL busy_rise_rd: lat=%0d data=%02h, required %0d/%02h", lat, dout, e.lat, e.data);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc; logic [DW-1:0] dout; exp_t e;
        access(0, 1'b1, 5'd9, 8'h22, lat, bc, dout);
        void'(sb.pop_front());
        access(0, 1'b0, 5'd9, 8'h00, lat, bc, dout);
        void'(sb.pop_front());
        t_addr[0] = 5'd9; t_din[0] = 8'h55; t_wr[0] = 1'b1;
        tick();
        t_wr[0] = 1'b0;
        total++;
        if (o_busy[0] !== 1'b1) begin
            bad++; $display("FAIL mid_accept: busy=%b, required 1", o_busy[0]);
        end
        #1 rst = 1'b0;
        #1;
        $display("txn dut=0 WR addr=9 data=55 reset in WAIT");
        total++;
        if ({o_dout[0], o_ready[0], o_busy[0], o_err[0]} !== 11'd0) begin
            bad++; $display("FAIL mid_reset: dout=%02h rdy=%b busy=%b err=%b, required all 0",
                            o_dout[0], o_ready[0], o_busy[0], o_err[0]);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        access(0, 1'b0, 5'd9, 8'h00, lat, bc, dout);
        e = sb.pop_front(); total++;
        if (lat !== e.lat || dout !== e.data) begin
            bad++; $display("FAIL mid_dropped: lat=%0d data=%02h, required %0d/%02h", lat, dout, e.lat, e.data);
        end
    endtask

    task automatic test_wrap();
        int lat, bc; logic [DW-1:0] dout; exp_t e;
        access(0, 1'b1, 5'd31, 8'h80, lat, bc, dout);
        void'(sb.pop_front());
        access(0, 1'b1, 5'd0, 8'h01, lat, bc, dout);
        void'(sb.pop_front());
        access(0, 1'b0, 5'd31, 8'h00, lat, bc, dout);
        e = sb.pop_front(); total++;
        if (lat !== e.lat || dout !== e.data) begin
            bad++; $display("FAIL wrap_31: lat=%0d data=%02h, required %0d/%02h", lat, dout, e.lat, e.data);
        end
        access(0, 1'b0, 5'd0, 8'h00, lat, bc, dout);
        e = sb.pop_front(); total++;
        if (lat !== e.lat || dout !== e.data) begin
            bad++; $display("FAIL wrap_0: lat=%0d data=%02h, required %0d/%02h", lat, dout, e.lat, e.data);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_held_strobe();
        test_simultaneous();
        test_busy_rise();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end
endmodule
